key_result_collector: RTL and testbench
=======================================

KEY_RESULT_COLLECTOR -- requirements
Module: key_result_collector

Interface
REQ-001 The block SHALL have parameter CORE_COUNT_LOG_2, default 2, meaning log2 of the number of decrypt cores.
REQ-002 The block SHALL have parameter CORE_COUNT, default 2**CORE_COUNT_LOG_2, meaning the number of decrypt cores.
REQ-003 The block SHALL have parameter KEY_W, default 22, meaning the secret key width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  meaning a level input; a rising edge launches a search.
REQ-007 The block SHALL have port core_found  input  CORE_COUNT  meaning bit i is core i's correct_key_found.
REQ-008 The block SHALL have port core_keys  input  CORE_COUNT*KEY_W  meaning core i's current key, carried on bits [i*KEY_W +: KEY_W].
REQ-009 The block SHALL have port core_done  input  CORE_COUNT  meaning bit i is high when core i has exhausted its key range.
REQ-010 The block SHALL have port stop_all  output  1  meaning a halt request to all cores.
REQ-011 The block SHALL have port found_key  output  KEY_W  meaning the latched winning key.
REQ-012 The block SHALL have port found_core  output  CORE_COUNT_LOG_2  meaning the index of the winning core.
REQ-013 The block SHALL have port status  output  2  meaning 00 IDLE, 01 SEARCH, 10 FOUND, 11 EXHAUSTED.
REQ-014 The block SHALL have port cycle_count  output  32  meaning the number of cycles spent in SEARCH.
REQ-015 The block SHALL have port display  output  24  meaning the value shown on the hex display.

Function
REQ-016 The block SHALL register start into start_q every cycle; start_edge = start & ~start_q.
REQ-017 In IDLE, on start_edge the FSM SHALL go to SEARCH next cycle, clearing cycle_count, found_key and found_core.
REQ-018 In SEARCH, cycle_count SHALL increment by 1 every cycle, saturating at 32'hFFFFFFFF; it freezes in all other states.
REQ-019 In SEARCH, if any core_found bit is high at cycle N, the following SHALL be true at cycle N+1: status = FOUND, found_core = lowest set index, found_key = that core's key slice sampled at N.
REQ-020 When several core_found bits are high in the same cycle, the lowest index SHALL win.
REQ-021 In SEARCH, if all core_done bits are high and no core_found bit is high, the FSM SHALL go to EXHAUSTED next cycle.
REQ-022 If core_found and all-done are high in the same cycle, FOUND SHALL take priority over EXHAUSTED.
REQ-023 stop_all SHALL be registered and high exactly when status is FOUND or EXHAUSTED.
REQ-024 FOUND and EXHAUSTED SHALL be terminal: start edges, core_found and core_done are ignored, and only reset exits.
REQ-025 In IDLE, core_found and core_done SHALL be ignored.
REQ-026 display SHALL be a registered value: 0 in IDLE; core 0 key slice, zero-extended, in SEARCH; found_key, zero-extended, in FOUND; 24'hFFFFFF in EXHAUSTED.
REQ-027 found_key and found_core SHALL hold their values until the next reset or the next start of a search.

Reset
REQ-028 When reset is high at a clock edge, the block SHALL go to IDLE regardless of state, including mid-SEARCH.
REQ-029 On reset, the following SHALL be true: status = 00, stop_all = 0, found_key = 0, found_core = 0, cycle_count = 0, display = 0, start_q = 0.
REQ-030 If start is held high through reset, the block SHALL detect an edge on the first cycle after reset release and enter SEARCH on the cycle after that.

Verification
REQ-031 The bench SHALL cover: reset; start rises; core_found = 4'b0100 with core 2 key = 22'h0A1B2C on the 10th SEARCH cycle -> next cycle status = 10, found_core = 2, found_key = 22'h0A1B2C, stop_all = 1, cycle_count = 10, display = 24'h0A1B2C.
REQ-032 The bench SHALL cover: core_found = 4'b1010 in the same cycle -> found_core = 1 and found_key = core 1 key.
REQ-033 The bench SHALL cover: core_done = 4'b1111 with core_found = 0 -> status = 11, stop_all = 1, display = 24'hFFFFFF; a later core_found pulse leaves status = 11.
REQ-034 The bench SHALL cover: core_done = 4'b1111 together with core_found = 4'b0001 -> status = 10, found_core = 0.
REQ-035 The bench SHALL cover: reset asserted during SEARCH after 50 cycles -> next cycle all outputs are at reset values; start held high -> SEARCH resumes 2 cycles after reset release with cycle_count restarting from 0.
REQ-036 The bench SHALL cover: start toggled 0-1-0-1 in FOUND -> no state change and found_key unchanged.

Source files
------------

// File: rtl/key_result_collector.sv
// Collects results from the key-search cores: latches the first winning key,
// detects exhaustion, counts search cycles and drives the halt and display outputs.
module key_result_collector #(
  parameter int CORE_COUNT_LOG_2 = 2,
  parameter int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2,
  parameter int KEY_W            = 22
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CORE_COUNT-1:0]       core_found,
  input  logic [CORE_COUNT*KEY_W-1:0] core_keys,
  input  logic [CORE_COUNT-1:0]       core_done,
  output logic                        stop_all,
  output logic [KEY_W-1:0]            found_key,
  output logic [CORE_COUNT_LOG_2-1:0] found_core,
  output logic [1:0]                  status,
  output logic [31:0]                 cycle_count,
  output logic [23:0]                 display
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_SEARCH    = 2'b01,
    ST_FOUND     = 2'b10,
    ST_EXHAUSTED = 2'b11
  } state_t;

  state_t                      state_q, state_d;
  logic                        start_q;
  logic                        start_edge;
  logic [31:0]                 cycle_count_q, cycle_count_d;
  logic [KEY_W-1:0]            found_key_q, found_key_d;
  logic [CORE_COUNT_LOG_2-1:0] found_core_q, found_core_d;
  logic                        stop_all_q, stop_all_d;
  logic [23:0]                 display_q, display_d;

  logic                        any_found;
  logic                        all_done;
  logic [CORE_COUNT_LOG_2-1:0] win_idx;
  logic [KEY_W-1:0]            win_key;

  assign start_edge = start & ~start_q;
  assign all_done   = &core_done;

  // Scan from the top so the lowest set index is the last one written and wins.
  always_comb begin
    any_found = 1'b0;
    win_idx   = '0;
    win_key   = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        any_found = 1'b1;
        win_idx   = CORE_COUNT_LOG_2'(i);
        win_key   = core_keys[i*KEY_W +: KEY_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    found_key_d   = found_key_q;
    found_core_d  = found_core_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d       = ST_SEARCH;
          cycle_count_d = '0;
          found_key_d   = '0;
          found_core_d  = '0;
        end
      end
      ST_SEARCH: begin
        if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        if (any_found) begin
          state_d      = ST_FOUND;
          found_key_d  = win_key;
          found_core_d = win_idx;
        end else if (all_done) begin
          state_d = ST_EXHAUSTED;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with status.
  always_comb begin
    stop_all_d = (state_d == ST_FOUND) || (state_d == ST_EXHAUSTED);
    display_d  = '0;
    case (state_d)
      ST_IDLE:      display_d = '0;
      ST_SEARCH:    display_d = 24'(core_keys[KEY_W-1:0]);
      ST_FOUND:     display_d = 24'(found_key_d);
      ST_EXHAUSTED: display_d = 24'hFF_FFFF;
      default:      display_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      cycle_count_q <= '0;
      found_key_q   <= '0;
      found_core_q  <= '0;
      stop_all_q    <= 1'b0;
      display_q     <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      cycle_count_q <= cycle_count_d;
      found_key_q   <= found_key_d;
      found_core_q  <= found_core_d;
      stop_all_q    <= stop_all_d;
      display_q     <= display_d;
    end
  end

  assign status      = state_q;
  assign stop_all    = stop_all_q;
  assign found_key   = found_key_q;
  assign found_core  = found_core_q;
  assign cycle_count = cycle_count_q;
  assign display     = display_q;

endmodule

// File: tb/tb_key_result_collector.sv
// Randomized and directed bench for key_result_collector, checked against a
// behavioural model of the search/found/exhausted rules.
module tb_key_result_collector;

  localparam int CLOG = 2;
  localparam int CN   = 4;
  localparam int KW   = 22;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CN-1:0]    core_found;
  logic [CN*KW-1:0] core_keys;
  logic [CN-1:0]    core_done;
  logic             stop_all;
  logic [KW-1:0]    found_key;
  logic [CLOG-1:0]  found_core;
  logic [1:0]       status;
  logic [31:0]      cycle_count;
  logic [23:0]      display;

  key_result_collector #(
    .CORE_COUNT_LOG_2(CLOG),
    .CORE_COUNT      (CN),
    .KEY_W           (KW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .core_found (core_found),
    .core_keys  (core_keys),
    .core_done  (core_done),
    .stop_all   (stop_all),
    .found_key  (found_key),
    .found_core (found_core),
    .status     (status),
    .cycle_count(cycle_count),
    .display    (display)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 search, 2 found, 3 exhausted.
  int          m_mode       = 0;
  logic        m_start_prev = 1'b0;
  logic [31:0] m_count      = '0;
  logic [KW-1:0] m_key      = '0;
  int          m_core       = 0;
  logic [23:0] m_display    = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CN*KW-1:0] randKeys();
    logic [CN*KW-1:0] k;
    for (int i = 0; i < CN; i++) k[i*KW +: KW] = KW'($urandom);
    return k;
  endfunction

  task automatic modelStep();
    logic rise;
    if (reset) begin
      m_mode = 0; m_start_prev = 1'b0; m_count = '0; m_key = '0; m_core = 0;
    end else begin
      rise = start && !m_start_prev;
      m_start_prev = start;
      if (m_mode == 0) begin
        if (rise) begin
          m_mode = 1; m_count = '0; m_key = '0; m_core = 0;
        end
      end else if (m_mode == 1) begin
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        if (core_found != '0) begin
          for (int i = CN - 1; i >= 0; i--) if (core_found[i]) m_core = i;
          m_key  = core_keys[m_core*KW +: KW];
          m_mode = 2;
        end else if (core_done == '1) begin
          m_mode = 3;
        end
      end
    end
    case (m_mode)
      1:       m_display = 24'(core_keys[KW-1:0]);
      2:       m_display = 24'(m_key);
      3:       m_display = 24'hFF_FFFF;
      default: m_display = '0;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("status",      64'(status),      64'(m_mode));
    checkOutput("stop_all",    64'(stop_all),    64'(m_mode >= 2));
    checkOutput("found_key",   64'(found_key),   64'(m_key));
    checkOutput("found_core",  64'(found_core),  64'(m_core));
    checkOutput("cycle_count", 64'(cycle_count), 64'(m_count));
    checkOutput("display",     64'(display),     64'(m_display));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [CN-1:0] f,
                               input logic [CN-1:0] d, input logic [CN*KW-1:0] k);
    reset = r; start = s; core_found = f; core_done = d; core_keys = k;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic runIdle(input int n, input logic s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, s, '0, '0, randKeys());
  endtask

  task automatic resetAndStart();
    applyStimulus(1'b1, 1'b0, '0, '0, randKeys());
    applyStimulus(1'b0, 1'b1, '0, '0, randKeys());
  endtask

  initial begin
    logic [CN*KW-1:0] k;
    logic             s_rand;
    logic [CN-1:0]    f_rand, d_rand;

    // Reset values
    applyStimulus(1'b1, 1'b0, '0, '0, randKeys());
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b1111, randKeys());
    checkOutput("rst_status", 64'(status), 64'd0);
    checkOutput("rst_display", 64'(display), 64'd0);

    // Found on the 10th search cycle
    applyStimulus(1'b0, 1'b1, '0, '0, randKeys());
    checkOutput("search_entry", 64'(status), 64'd1);
    checkOutput("search_cnt0", 64'(cycle_count), 64'd0);
    runIdle(9, 1'b1);
    k = randKeys();
    k[2*KW +: KW] = 22'h0A1B2C;
    applyStimulus(1'b0, 1'b1, 4'b0100, '0, k);
    checkOutput("f10_status", 64'(status), 64'd2);
    checkOutput("f10_core", 64'(found_core), 64'd2);
    checkOutput("f10_key", 64'(found_key), 64'h0A1B2C);
    checkOutput("f10_stop", 64'(stop_all), 64'd1);
    checkOutput("f10_count", 64'(cycle_count), 64'd10);
    checkOutput("f10_display", 64'(display), 64'h0A1B2C);

    // Start toggling and other inputs are ignored in FOUND
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 4'(i + 1), 4'b1111, randKeys());
      checkOutput("found_hold_status", 64'(status), 64'd2);
      checkOutput("found_hold_key", 64'(found_key), 64'h0A1B2C);
    end

    // Multiple found bits: lowest index wins
    resetAndStart();
    runIdle(3, 1'b1);
    k = randKeys();
    k[1*KW +: KW] = 22'h155AA3;
    applyStimulus(1'b0, 1'b1, 4'b1010, '0, k);
    checkOutput("multi_core", 64'(found_core), 64'd1);
    checkOutput("multi_key", 64'(found_key), 64'h155AA3);

    // Exhaustion, then a found pulse is ignored
    resetAndStart();
    runIdle(5, 1'b1);
    applyStimulus(1'b0, 1'b1, '0, 4'b1111, randKeys());
    checkOutput("exh_status", 64'(status), 64'd3);
    checkOutput("exh_stop", 64'(stop_all), 64'd1);
    checkOutput("exh_display", 64'(display), 64'hFFFFFF);
    applyStimulus(1'b0, 1'b1, 4'b0100, '0, randKeys());
    applyStimulus(1'b0, 1'b1, '0, '0, randKeys());
    checkOutput("exh_hold", 64'(status), 64'd3);

    // Found beats all-done in the same cycle
    resetAndStart();
    runIdle(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1111, randKeys());
    checkOutput("prio_status", 64'(status), 64'd2);
    checkOutput("prio_core", 64'(found_core), 64'd0);

    // Reset mid-search with start held high
    resetAndStart();
    runIdle(50, 1'b1);
    checkOutput("mid_count", 64'(cycle_count), 64'd50);
    applyStimulus(1'b1, 1'b1, '0, '0, randKeys());
    checkOutput("mid_rst_status", 64'(status), 64'd0);
    checkOutput("mid_rst_count", 64'(cycle_count), 64'd0);
    checkOutput("mid_rst_stop", 64'(stop_all), 64'd0);
    applyStimulus(1'b0, 1'b1, '0, '0, randKeys());
    checkOutput("resume_status", 64'(status), 64'd1);
    checkOutput("resume_count", 64'(cycle_count), 64'd0);
    runIdle(2, 1'b1);
    checkOutput("resume_count2", 64'(cycle_count), 64'd2);

    // Random traffic against the model
    s_rand = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) s_rand = ~s_rand;
      f_rand = ($urandom_range(0, 19) == 0) ? CN'($urandom) : '0;
      d_rand = ($urandom_range(0, 24) == 0) ? '1 : CN'($urandom);
      applyStimulus(($urandom_range(0, 79) == 0), s_rand, f_rand, d_rand, randKeys());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
